// File: rtl/pc_flow_unit.sv
// pc_flow_unit: program counter with increment / jump / conditional branch
// selection and an internal call/return stack.
//
// One operation is applied per enabled clock edge. The new pc is visible
// right after the edge that applied the op, and 'taken' is registered so it
// lines up with that new pc value. Stack overflow and underflow attempts
// do not corrupt the stack. They fall through to pc+1 and raise sticky
// error flags instead.
//
// There are no valid/ready handshakes on this block. 'en' is a plain
// qualifier: when it is low, all architectural state holds and only
// err_clr acts.

module pc_flow_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                RS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int               CNT_W    = $clog2(RS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] target,
    input  logic [3:0]        cond_mask,
    input  logic [3:0]        flags,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] pc,
    output logic              taken,
    output logic [CNT_W-1:0]  rs_count,
    output logic              rs_full,
    output logic              rs_empty,
    output logic              err_ovf,
    output logic              err_unf
);

    // Opcode encoding from the control unit; 5..7 fall into the INC default.
    localparam logic [2:0] OP_INC  = 3'd0;
    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_BCC  = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

    // Stack index width. RS_DEPTH >= 2, so this is at least 1 bit.
    localparam int IDX_W = $clog2(RS_DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RS_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    // Architectural state.
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic              taken_q, taken_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              ovf_q,   ovf_d;
    logic              unf_q,   unf_d;

    // Return-address storage. It has no reset because its contents are only
    // meaningful below cnt_q.
    logic [ADDR_W-1:0] stack_q [RS_DEPTH];

    // Datapath helpers.
    logic [ADDR_W-1:0] pc_inc;
    logic [IDX_W-1:0]  push_idx;
    logic [IDX_W-1:0]  pop_idx;
    logic              full;
    logic              empty;
    logic              cond_hit;
    logic              push;

    // Sequential pc+1 wraps naturally at 2^ADDR_W. The push slot is the
    // current count and the pop slot is one below it. Both indices are
    // truncated casts: a push only happens when not full and a pop only
    // when not empty, so the truncated value is always in range whenever
    // it is actually used.
    always_comb begin
        pc_inc   = pc_q + ADDR_W'(1);
        push_idx = IDX_W'(cnt_q);
        pop_idx  = IDX_W'(cnt_q - ONE_C);
        full     = (cnt_q == DEPTH_C);
        empty    = (cnt_q == '0);
        cond_hit = |(cond_mask & flags);
    end

    // Next-state selection for pc, stack depth, taken and the sticky errors.
    // Clearing is applied first, so an error raised in the same cycle as
    // err_clr overrides the clear.
    always_comb begin
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        taken_d = 1'b0;
        push    = 1'b0;
        ovf_d   = ovf_q & ~err_clr;
        unf_d   = unf_q & ~err_clr;

        if (en) begin
            pc_d = pc_inc;
            case (op)
                OP_JMP: begin
                    pc_d    = target;
                    taken_d = 1'b1;
                end
                OP_BCC: begin
                    if (cond_hit) begin
                        pc_d    = target;
                        taken_d = 1'b1;
                    end
                end
                OP_CALL: begin
                    if (!full) begin
                        push    = 1'b1;
                        cnt_d   = cnt_q + ONE_C;
                        pc_d    = target;
                        taken_d = 1'b1;
                    end else begin
                        ovf_d   = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!empty) begin
                        cnt_d   = cnt_q - ONE_C;
                        pc_d    = stack_q[pop_idx];
                        taken_d = 1'b1;
                    end else begin
                        unf_d   = 1'b1;
                    end
                end
                default: begin
                    // INC and the unused encodings: sequential fetch.
                end
            endcase
        end
    end

    // Control registers. Reset is synchronous and active-low, and it
    // overrides en, op and err_clr.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            taken_q <= taken_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Return-address push. The stored value is the wrapped address of the
    // instruction after the CALL.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign pc       = pc_q;
    assign taken    = taken_q;
    assign rs_count = cnt_q;
    assign rs_full  = full;
    assign rs_empty = empty;
    assign err_ovf  = ovf_q;
    assign err_unf  = unf_q;

endmodule

// File: tb/tb_pc_flow_unit.sv
// Directed testbench for pc_flow_unit (ADDR_W=16, RS_DEPTH=8, RESET_PC=0x0010).
// Inputs are driven just after a rising edge, and outputs are sampled 1ns
// after the next rising edge.

module tb_pc_flow_unit;

    localparam int          AW    = 16;
    localparam int          DEPTH = 8;
    localparam int          CW    = 4;
    localparam logic [15:0] RPC   = 16'h0010;

    localparam logic [2:0] INC  = 3'd0;
    localparam logic [2:0] JMP  = 3'd1;
    localparam logic [2:0] BCC  = 3'd2;
    localparam logic [2:0] CALL = 3'd3;
    localparam logic [2:0] RET  = 3'd4;

    logic          clk;
    logic          rst;
    logic          en;
    logic [2:0]    op;
    logic [AW-1:0] target;
    logic [3:0]    cond_mask;
    logic [3:0]    flags;
    logic          err_clr;
    logic [AW-1:0] pc;
    logic          taken;
    logic [CW-1:0] rs_count;
    logic          rs_full;
    logic          rs_empty;
    logic          err_ovf;
    logic          err_unf;

    int total = 0;
    int bad   = 0;

    // Expected return-address stack (LIFO model).
    logic [AW-1:0] exp_q[$];

    pc_flow_unit #(
        .ADDR_W  (AW),
        .RS_DEPTH(DEPTH),
        .RESET_PC(RPC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .op       (op),
        .target   (target),
        .cond_mask(cond_mask),
        .flags    (flags),
        .err_clr  (err_clr),
        .pc       (pc),
        .taken    (taken),
        .rs_count (rs_count),
        .rs_full  (rs_full),
        .rs_empty (rs_empty),
        .err_ovf  (err_ovf),
        .err_unf  (err_unf)
    );

    // Clock and initial input state.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: apply one cycle of inputs and return 1ns after the edge that
    // consumed them.
    task automatic drive(input logic r, input logic e, input logic [2:0] o,
                         input logic [AW-1:0] t, input logic [3:0] m,
                         input logic [3:0] f, input logic c);
        rst = r; en = e; op = o; target = t; cond_mask = m; flags = f; err_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, INC, 16'h0000, 4'h0, 4'h0, 1'b0);
        drive(1'b0, 1'b1, JMP, 16'h5555, 4'h0, 4'h0, 1'b0);
        total++;
        if ({pc, taken, rs_count, rs_empty, rs_full, err_ovf, err_unf} !==
            {RPC, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state pc=%h tk=%b cnt=%0d emp=%b full=%b ovf=%b unf=%b want pc=%h tk=0 cnt=0 emp=1 full=0 ovf=0 unf=0",
                     pc, taken, rs_count, rs_empty, rs_full, err_ovf, err_unf, RPC);
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, INC, 16'h0000, 4'h0, 4'h0, 1'b0);
            total++;
            if ({pc, taken, rs_empty} !== {RPC + 16'(i), 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL reset_inc[%0d] pc=%h tk=%b emp=%b want pc=%h tk=0 emp=1",
                         i, pc, taken, rs_empty, RPC + 16'(i));
            end
        end
    endtask

    task automatic test_wrap_hold();
        drive(1'b1, 1'b1, JMP, 16'hFFFF, 4'h0, 4'h0, 1'b0);
        total++;
        if ({pc, taken} !== {16'hFFFF, 1'b1}) begin
            bad++;
            $display("FAIL jmp pc=%h tk=%b want pc=ffff tk=1", pc, taken);
        end
        drive(1'b1, 1'b1, INC, 16'h0000, 4'h0, 4'h0, 1'b0);
        total++;
        if ({pc, taken} !== {16'h0000, 1'b0}) begin
            bad++;
            $display("FAIL wrap pc=%h tk=%b want pc=0000 tk=0", pc, taken);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, JMP, 16'h1234, 4'h0, 4'h0, 1'b0);
            total++;
            if ({pc, taken} !== {16'h0000, 1'b0}) begin
                bad++;
                $display("FAIL hold[%0d] pc=%h tk=%b want pc=0000 tk=0", i, pc, taken);
            end
        end
        // A hold right after a redirect must drop taken.
        drive(1'b1, 1'b1, JMP, 16'h2000, 4'h0, 4'h0, 1'b0);
        drive(1'b1, 1'b0, INC, 16'h0000, 4'h0, 4'h0, 1'b0);
        total++;
        if ({pc, taken} !== {16'h2000, 1'b0}) begin
            bad++;
            $display("FAIL hold_after_jmp pc=%h tk=%b want pc=2000 tk=0", pc, taken);
        end
    endtask

    task automatic test_bcc();
        logic [3:0]  fl [5] = '{4'b0001, 4'b0010, 4'b1111, 4'b1010, 4'b1001};
        logic [3:0]  mk [5] = '{4'b0001, 4'b0001, 4'b0000, 4'b1000, 4'b0110};
        logic [15:0] tg [5] = '{16'h0040, 16'h0077, 16'h0077, 16'h0080, 16'h0090};
        logic [15:0] ep [5] = '{16'h0040, 16'h0041, 16'h0042, 16'h0080, 16'h0081};
        logic        et [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, BCC, tg[i], mk[i], fl[i], 1'b0);
            total++;
            if ({pc, taken} !== {ep[i], et[i]}) begin
                bad++;
                $display("FAIL bcc[%0d] pc=%h tk=%b want pc=%h tk=%b", i, pc, taken, ep[i], et[i]);
            end
        end
    endtask

    task automatic test_calls();
        logic [15:0] mpc;
        logic [15:0] tgt;
        logic [15:0] ret;
        exp_q.delete();
        drive(1'b1, 1'b1, JMP, 16'h0100, 4'h0, 4'h0, 1'b0);
        mpc = 16'h0100;
        for (int i = 0; i < DEPTH; i++) begin
            tgt = 16'h0200 + 16'(i * 16);
            exp_q.push_back(mpc + 16'h0001);
            drive(1'b1, 1'b1, CALL, tgt, 4'h0, 4'h0, 1'b0);
            mpc = tgt;
            total++;
            if ({pc, taken, rs_count} !== {mpc, 1'b1, 4'(i + 1)}) begin
                bad++;
                $display("FAIL call[%0d] pc=%h tk=%b cnt=%0d want pc=%h tk=1 cnt=%0d",
                         i, pc, taken, rs_count, mpc, i + 1);
            end
        end
        total++;
        if ({rs_full, rs_empty, err_ovf} !== 3'b100) begin
            bad++;
            $display("FAIL stack_full full=%b emp=%b ovf=%b want 1 0 0", rs_full, rs_empty, err_ovf);
        end
        // The 9th call overflows and falls through to pc+1 (0x0271).
        drive(1'b1, 1'b1, CALL, 16'h0999, 4'h0, 4'h0, 1'b0);
        mpc = mpc + 16'h0001;
        total++;
        if ({pc, taken, rs_count, rs_full, err_ovf} !== {mpc, 1'b0, 4'd8, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL call_ovf pc=%h tk=%b cnt=%0d full=%b ovf=%b want pc=%h tk=0 cnt=8 full=1 ovf=1",
                     pc, taken, rs_count, rs_full, err_ovf, mpc);
        end
        for (int i = 0; i < DEPTH; i++) begin
            ret = exp_q.pop_back();
            drive(1'b1, 1'b1, RET, 16'h0000, 4'h0, 4'h0, 1'b0);
            total++;
            if ({pc, taken, rs_count} !== {ret, 1'b1, 4'(DEPTH - 1 - i)}) begin
                bad++;
                $display("FAIL ret[%0d] pc=%h tk=%b cnt=%0d want pc=%h tk=1 cnt=%0d",
                         i, pc, taken, rs_count, ret, DEPTH - 1 - i);
            end
        end
        total++;
        if ({pc, rs_empty, rs_full, err_ovf} !== {16'h0101, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL stack_drained pc=%h emp=%b full=%b ovf=%b want pc=0101 emp=1 full=0 ovf=1",
                     pc, rs_empty, rs_full, err_ovf);
        end
    endtask

    task automatic test_underflow_clear();
        drive(1'b1, 1'b1, RET, 16'h0000, 4'h0, 4'h0, 1'b0);
        total++;
        if ({pc, taken, rs_count, err_unf, err_ovf} !== {16'h0102, 1'b0, 4'd0, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL ret_unf pc=%h tk=%b cnt=%0d unf=%b ovf=%b want pc=0102 tk=0 cnt=0 unf=1 ovf=1",
                     pc, taken, rs_count, err_unf, err_ovf);
        end
        drive(1'b1, 1'b1, INC, 16'h0000, 4'h0, 4'h0, 1'b1);
        total++;
        if ({pc, err_unf, err_ovf} !== {16'h0103, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL err_clr pc=%h unf=%b ovf=%b want pc=0103 unf=0 ovf=0", pc, err_unf, err_ovf);
        end
        drive(1'b1, 1'b1, RET, 16'h0000, 4'h0, 4'h0, 1'b1);
        total++;
        if ({pc, taken, err_unf, err_ovf} !== {16'h0104, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL clr_vs_unf pc=%h tk=%b unf=%b ovf=%b want pc=0104 tk=0 unf=1 ovf=0",
                     pc, taken, err_unf, err_ovf);
        end
        // err_clr still acts while en is low; pc holds.
        drive(1'b1, 1'b0, RET, 16'h0000, 4'h0, 4'h0, 1'b1);
        total++;
        if ({pc, err_unf} !== {16'h0104, 1'b0}) begin
            bad++;
            $display("FAIL clr_while_hold pc=%h unf=%b want pc=0104 unf=0", pc, err_unf);
        end
    endtask

    task automatic test_call_wrap_and_spare_ops();
        drive(1'b1, 1'b1, JMP, 16'hFFFF, 4'h0, 4'h0, 1'b0);
        drive(1'b1, 1'b1, CALL, 16'h0050, 4'h0, 4'h0, 1'b0);
        total++;
        if ({pc, taken, rs_count} !== {16'h0050, 1'b1, 4'd1}) begin
            bad++;
            $display("FAIL call_wrap pc=%h tk=%b cnt=%0d want pc=0050 tk=1 cnt=1", pc, taken, rs_count);
        end
        drive(1'b1, 1'b1, RET, 16'h0000, 4'h0, 4'h0, 1'b0);
        total++;
        if ({pc, taken, rs_count} !== {16'h0000, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL ret_wrap pc=%h tk=%b cnt=%0d want pc=0000 tk=1 cnt=0", pc, taken, rs_count);
        end
        drive(1'b1, 1'b1, 3'd5, 16'h0777, 4'hF, 4'hF, 1'b0);
        drive(1'b1, 1'b1, 3'd7, 16'h0777, 4'hF, 4'hF, 1'b0);
        total++;
        if ({pc, taken, rs_count} !== {16'h0002, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL spare_ops pc=%h tk=%b cnt=%0d want pc=0002 tk=0 cnt=0", pc, taken, rs_count);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, RET, 16'h0000, 4'h0, 4'h0, 1'b0);
        drive(1'b1, 1'b1, JMP, 16'h0300, 4'h0, 4'h0, 1'b0);
        drive(1'b1, 1'b1, CALL, 16'h0310, 4'h0, 4'h0, 1'b0);
        drive(1'b1, 1'b1, CALL, 16'h0320, 4'h0, 4'h0, 1'b0);
        drive(1'b1, 1'b1, CALL, 16'h0330, 4'h0, 4'h0, 1'b0);
        total++;
        if ({pc, rs_count, err_unf} !== {16'h0330, 4'd3, 1'b1}) begin
            bad++;
            $display("FAIL pre_reset pc=%h cnt=%0d unf=%b want pc=0330 cnt=3 unf=1", pc, rs_count, err_unf);
        end
        drive(1'b0, 1'b1, CALL, 16'h0340, 4'h0, 4'h0, 1'b0);
        total++;
        if ({pc, taken, rs_count, rs_empty, err_ovf, err_unf} !== {RPC, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset pc=%h tk=%b cnt=%0d emp=%b ovf=%b unf=%b want pc=%h tk=0 cnt=0 emp=1 ovf=0 unf=0",
                     pc, taken, rs_count, rs_empty, err_ovf, err_unf, RPC);
        end
        drive(1'b1, 1'b1, RET, 16'h0000, 4'h0, 4'h0, 1'b0);
        total++;
        if ({pc, taken, rs_count, err_unf} !== {RPC + 16'h0001, 1'b0, 4'd0, 1'b1}) begin
            bad++;
            $display("FAIL ret_after_reset pc=%h tk=%b cnt=%0d unf=%b want pc=%h tk=0 cnt=0 unf=1",
                     pc, taken, rs_count, err_unf, RPC + 16'h0001);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; op = INC; target = '0;
        cond_mask = '0; flags = '0; err_clr = 1'b0;
        test_reset();
        test_wrap_hold();
        test_bcc();
        test_calls();
        test_underflow_clear();
        test_call_wrap_and_spare_ops();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_flow_unit.md
Name: pc_flow_unit

Overview:
Parametrised program-flow unit that supersedes the single-register program counter and its separate branch qualification logic. Owns the PC, increment/jump/conditional-branch selection, and an internal call/return stack of configurable depth with full/empty status and sticky overflow/underflow error flags. It sits between the control unit (op, target, condition mask), the flags register (Z/N/C/V), and instruction-memory addressing.

Parameters:
ADDR_W, 16, PC and target width in bits (>=4)
RS_DEPTH, 8, return-stack entries (>=2)
RESET_PC, 0, PC value loaded on reset
CNT_W, $clog2(RS_DEPTH+1), width of the stack occupancy count (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-low reset
en  in  1  advance enable; 0 = full hold
op  in  3  0 INC, 1 JMP, 2 BCC, 3 CALL, 4 RET, 5-7 treated as INC
target  in  ADDR_W  jump/branch/call destination
cond_mask  in  4  BCC qualifier, bit order {V,C,N,Z} = [3:0]
flags  in  4  current flags, same bit order as cond_mask
err_clr  in  1  clears sticky error flags
pc  out  ADDR_W  current program counter
taken  out  1  registered, high one cycle after a redirect (JMP, taken BCC, successful CALL/RET)
rs_count  out  CNT_W  current stack occupancy
rs_full  out  1  rs_count == RS_DEPTH (combinational from count)
rs_empty  out  1  rs_count == 0
err_ovf  out  1  sticky: CALL attempted while full
err_unf  out  1  sticky: RET attempted while empty

Behaviour:
- Reset (rst==0 at clk edge): pc=RESET_PC, rs_count=0, taken=0, err_ovf=0, err_unf=0. Stack contents are don't-care. Reset overrides en, op, and err_clr. Reset mid-sequence discards all pending returns.
- en==0: pc, rs_count, stack, and errors hold; taken<=0. err_clr is still honoured.
- en==1, per op, with pc+1 wrapping 2^ADDR_W-1 -> 0:
  - INC: pc<=pc+1; taken<=0.
  - JMP: pc<=target; taken<=1.
  - BCC: if |(cond_mask & flags), pc<=target and taken<=1. Otherwise pc<=pc+1 and taken<=0. cond_mask==0 is never taken.
  - CALL, not full: stack[rs_count]<=pc+1 (wrapped), rs_count+1, pc<=target, taken<=1.
  - CALL, full: no push, rs_count unchanged, pc<=pc+1, taken<=0, err_ovf<=1.
  - RET, not empty: pc<=stack[rs_count-1], rs_count-1, taken<=1.
  - RET, empty: pc<=pc+1, taken<=0, err_unf<=1.
- Latency: pc reflects the op applied at edge N immediately after edge N. taken is aligned with the new pc value.
- flags and cond_mask are sampled in the same cycle as op (no internal flag latching).
- Error flags: err_clr==1 clears both. A new error in the same cycle as err_clr wins, so that flag ends at 1 and the other clears.
- Stack storage is a register array indexed by rs_count. There is no read-before-write hazard because only one op occurs per cycle.
- target is not range-checked; any ADDR_W value is legal.

Test Plan:
- Reset/INC: hold rst=0 for 2 cycles with RESET_PC=16'h0010, then release with en=1, op=INC for 3 cycles -> pc 0x0010, 0x0011, 0x0012, 0x0013; taken=0; rs_empty=1.
- Wrap and hold: pc=0xFFFF with INC -> pc=0x0000. Then en=0 for 2 cycles with op=JMP, target=0x1234 -> pc stays 0x0000 and taken=0.
- BCC: flags=4'b0001 (Z), cond_mask=4'b0001, target=0x0040 -> pc=0x0040, taken=1. Then flags=4'b0010, mask=4'b0001 -> pc=0x0041, taken=0. Then mask=0 with flags=4'hF -> not taken.
- Nested calls to overflow (RS_DEPTH=8): 8 CALLs from pc=0x0100 to successive targets -> rs_count=8, rs_full=1. A 9th CALL -> err_ovf=1, pc+1, rs_count stays 8. Then 8 RETs -> return addresses popped in LIFO order (first RET returns the 8th call's pc+1), rs_empty=1.
- Underflow and clear: RET while empty -> err_unf=1, pc+1, taken=0. Then err_clr=1 with op=INC -> err_unf=0. Then err_clr=1 with RET while empty -> err_unf remains 1.
- Reset mid-operation: 3 CALLs, then rst=0 for one cycle -> pc=RESET_PC, rs_count=0, errors 0. Subsequent RET -> err_unf=1.
